llc_rst_flush_seq: RTL and testbench

- Sequencer for LLC reset and flush sweeps.
- Accepts one reset or flush command and walks every LLC set in order, issuing one per-set sweep token toward the lookup/update pipeline.
- Limits in-flight tokens with a credit counter that is returned by the update stage's resume-clear pulses.
- Raises the testbench/CPU done handshake only after the last set has completed, and drives the rst/flush stall flags consumed by the update stage.

---
 rtl/llc_rst_flush_seq_if.sv | 18 +
 rtl/llc_rst_flush_seq.sv | 60 ++++++
 tb/tb_llc_rst_flush_seq.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/llc_rst_flush_seq_if.sv
// llc_rst_flush_seq_if: command, sweep-token, completion and done signals of the LLC reset/flush sequencer
// master = sequencer side, slave = requester/pipeline side
interface llc_rst_flush_seq_if #(parameter int SET_W = 9);
  logic rst_req, flush_req, cmd_ready;
  logic sweep_valid, sweep_ready, sweep_is_rst, sweep_is_flush, sweep_last, sweep_cmpl;
  logic [SET_W-1:0] sweep_set;
  logic rst_stall, flush_stall, done_valid, done_ready;
  modport master(
    input rst_req, flush_req, sweep_ready, sweep_cmpl, done_ready,
    output cmd_ready, sweep_valid, sweep_set, sweep_is_rst, sweep_is_flush, sweep_last,
    rst_stall, flush_stall, done_valid
  );
  modport slave(
    output rst_req, flush_req, sweep_ready, sweep_cmpl, done_ready,
    input cmd_ready, sweep_valid, sweep_set, sweep_is_rst, sweep_is_flush, sweep_last,
    rst_stall, flush_stall, done_valid
  );
endinterface

// File: rtl/llc_rst_flush_seq.sv
// llc_rst_flush_seq: walks every LLC set once per reset/flush command, credit-limited sweep tokens, done handshake
// ports: clk, rst (sync, active-low), bus (master): rst_req/flush_req/cmd_ready command, sweep_* token channel,
//        sweep_cmpl completion pulses, rst_stall/flush_stall flags, done_valid/done_ready finish handshake
module llc_rst_flush_seq #(
  parameter int SETS = 512,
  parameter int SET_W = 9,
  parameter int MAX_INFLIGHT = 2
) (
  input logic clk,
  input logic rst,
  llc_rst_flush_seq_if.master bus
);
  typedef enum logic [2:0] {IDLE, RST_SWEEP, FLUSH_SWEEP, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [2:0] infl, infl_n;
  logic [SET_W-1:0] set_n;
  logic hs, cmpl, sweeping, sweeping_n, valid_n;
  // all outputs are registered from next-state values; sweep_set doubles as the set counter
  always_comb begin
    hs = bus.sweep_valid & bus.sweep_ready;
    cmpl = bus.sweep_cmpl & (infl != 3'd0);
    infl_n = infl + {2'b0, hs} - {2'b0, cmpl};
    sweeping = state == RST_SWEEP || state == FLUSH_SWEEP;
    set_n = sweeping ? bus.sweep_set + SET_W'(hs) : '0;
    state_n = state == IDLE ? (bus.rst_req ? RST_SWEEP : bus.flush_req ? FLUSH_SWEEP : IDLE)
            : sweeping ? (hs && bus.sweep_last ? DRAIN : state)
            : state == DRAIN ? (infl_n == 3'd0 ? DONE : DRAIN)
            : (bus.done_ready ? IDLE : DONE);
    sweeping_n = state_n == RST_SWEEP || state_n == FLUSH_SWEEP;
    valid_n = sweeping_n && infl_n < 3'(MAX_INFLIGHT);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      infl <= 3'd0;
      bus.cmd_ready <= 1'b1;
      bus.sweep_valid <= 1'b0;
      bus.sweep_set <= '0;
      bus.sweep_is_rst <= 1'b0;
      bus.sweep_is_flush <= 1'b0;
      bus.sweep_last <= 1'b0;
      bus.rst_stall <= 1'b0;
      bus.flush_stall <= 1'b0;
      bus.done_valid <= 1'b0;
    end else begin
      state <= state_n;
      infl <= infl_n;
      bus.cmd_ready <= state_n == IDLE;
      bus.sweep_valid <= valid_n;
      bus.sweep_set <= set_n;
      bus.sweep_is_rst <= valid_n && state_n == RST_SWEEP;
      bus.sweep_is_flush <= valid_n && state_n == FLUSH_SWEEP;
      bus.sweep_last <= sweeping_n && set_n == SET_W'(SETS - 1);
      // stall flags latch the command kind and hold through DRAIN/DONE until IDLE
      bus.rst_stall <= state_n == RST_SWEEP || (state_n != IDLE && bus.rst_stall);
      bus.flush_stall <= state_n == FLUSH_SWEEP || (state_n != IDLE && bus.flush_stall);
      bus.done_valid <= state_n == DONE;
    end
  end
endmodule

// File: tb/tb_llc_rst_flush_seq.sv
// tb_llc_rst_flush_seq: table vectors, directed sweeps and a randomized run against a behavioural model
module tb_llc_rst_flush_seq;
  localparam int SETS = 8;
  localparam int SET_W = 3;
  localparam int MAXI = 2;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  llc_rst_flush_seq_if #(.SET_W(SET_W)) bus();
  llc_rst_flush_seq #(.SETS(SETS), .SET_W(SET_W), .MAX_INFLIGHT(MAXI)) dut(.clk(clk), .rst(rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  typedef struct {
    logic r, rq, fq, rdy, c, dr;
    logic [10:0] exp;
  } vec_t;
  vec_t tbl[16];
  logic [10:0] obs;
  assign obs = {bus.cmd_ready, bus.sweep_valid, bus.sweep_set, bus.sweep_is_rst, bus.sweep_is_flush,
                bus.sweep_last, bus.rst_stall, bus.flush_stall, bus.done_valid};
  int m_act, m_next, m_out;
  bit m_all, m_done;

  function automatic logic [10:0] e(input logic cr, v, input int s, input logic r, f, l, rs, fs, dv);
    return {cr, v, 3'(s), r, f, l, rs, fs, dv};
  endfunction

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, got, exp);
    end
  endtask

  task automatic drive(input logic r, rq, fq, rdy, c, dr);
    rst = r;
    bus.rst_req = rq;
    bus.flush_req = fq;
    bus.sweep_ready = rdy;
    bus.sweep_cmpl = c;
    bus.done_ready = dr;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // runs an already-accepted sweep to DONE; completions return one cycle after each handshake
  task automatic sweep(input bit kr, input int stall_at, input int hold);
    int k;
    bit hs_prev, hs_now, stalled;
    k = 0;
    hs_prev = 0;
    stalled = 0;
    for (int c = 0; c < 80 && !bus.done_valid; c++) begin
      if (bus.sweep_valid && k == stall_at && !stalled) begin
        stalled = 1;
        for (int i = 0; i < 5; i++) begin
          drive(1, 0, 0, 0, hs_prev, 0);
          hs_prev = 0;
          step;
          check("stall_hold", 11'({bus.sweep_valid, bus.sweep_set}), 11'({1'b1, 3'(stall_at)}));
        end
      end
      if (bus.sweep_valid) begin
        check("token", 11'({bus.sweep_set, bus.sweep_is_rst, bus.sweep_is_flush, bus.sweep_last, bus.rst_stall, bus.flush_stall}),
              11'({3'(k), kr, !kr, k == SETS - 1, kr, !kr}));
        k++;
      end else
        check("drain_stall", 11'({bus.rst_stall, bus.flush_stall}), 11'({kr, !kr}));
      hs_now = bus.sweep_valid;
      drive(1, 0, 0, 1, hs_prev, 0);
      step;
      hs_prev = hs_now;
    end
    check("token_count", 11'(k), 11'(SETS));
    check("done", obs, e(0, 0, 0, 0, 0, 0, kr, !kr, 1));
    for (int i = 0; i < hold; i++) begin
      drive(1, 0, 1, 0, 0, 0);
      step;
      check("done_hold", obs, e(0, 0, 0, 0, 0, 0, kr, !kr, 1));
    end
    drive(1, 0, 0, 0, 0, 1);
    step;
    check("done_exit", obs, e(1, 0, 0, 0, 0, 0, 0, 0, 0));
    drive(1, 0, 0, 0, 0, 0);
    step;
    check("idle_after", obs, e(1, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  function automatic logic [10:0] m_exp();
    bit sw, v;
    sw = m_act != 0 && !m_all;
    v = sw && m_out < MAXI;
    return {m_act == 0, v, 3'(m_next % SETS), v && m_act == 1, v && m_act == 2,
            sw && m_next == SETS - 1, m_act == 1, m_act == 2, m_done};
  endfunction

  task automatic m_update(input logic r, rq, fq, rdy, c, dr, input bit v);
    bit hs, ce;
    if (!r) begin
      m_act = 0; m_next = 0; m_out = 0; m_all = 0; m_done = 0;
    end else if (m_act == 0) begin
      if (rq) m_act = 1;
      else if (fq) m_act = 2;
      if (m_act != 0) begin m_next = 0; m_all = 0; end
    end else if (m_done) begin
      if (dr) begin m_act = 0; m_done = 0; end
    end else begin
      hs = v && rdy;
      ce = c && m_out > 0;
      if (hs) begin
        m_next++;
        if (m_next == SETS) m_all = 1;
      end
      m_out += int'(hs) - int'(ce);
      if (m_all && m_out == 0) m_done = 1;
    end
  endtask

  initial begin
    logic r, rq, fq, rdy, c, dr;
    logic [10:0] ex;
    drive(0, 0, 0, 0, 0, 0);
    tbl[0]  = '{0, 0, 0, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1, 1, 1, 0, 0, 0, e(0, 1, 0, 1, 0, 0, 1, 0, 0)};
    tbl[2]  = '{1, 0, 1, 0, 0, 0, e(0, 1, 0, 1, 0, 0, 1, 0, 0)};
    tbl[3]  = '{1, 0, 0, 1, 0, 0, e(0, 1, 1, 1, 0, 0, 1, 0, 0)};
    tbl[4]  = '{1, 0, 0, 1, 0, 0, e(0, 0, 2, 0, 0, 0, 1, 0, 0)};
    tbl[5]  = '{1, 0, 0, 1, 0, 0, e(0, 0, 2, 0, 0, 0, 1, 0, 0)};
    tbl[6]  = '{1, 0, 0, 0, 1, 0, e(0, 1, 2, 1, 0, 0, 1, 0, 0)};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[8]  = '{1, 0, 1, 0, 0, 0, e(0, 1, 0, 0, 1, 0, 0, 1, 0)};
    tbl[9]  = '{1, 0, 0, 1, 0, 0, e(0, 1, 1, 0, 1, 0, 0, 1, 0)};
    tbl[10] = '{1, 0, 0, 1, 0, 0, e(0, 0, 2, 0, 0, 0, 0, 1, 0)};
    tbl[11] = '{1, 0, 0, 1, 1, 0, e(0, 1, 2, 0, 1, 0, 0, 1, 0)};
    tbl[12] = '{1, 0, 0, 1, 1, 0, e(0, 1, 3, 0, 1, 0, 0, 1, 0)};
    tbl[13] = '{1, 1, 0, 0, 0, 0, e(0, 1, 3, 0, 1, 0, 0, 1, 0)};
    tbl[14] = '{0, 0, 0, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[15] = '{1, 0, 0, 0, 0, 0, e(1, 0, 0, 0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].r, tbl[i].rq, tbl[i].fq, tbl[i].rdy, tbl[i].c, tbl[i].dr);
      step;
      check($sformatf("table[%0d]", i), obs, tbl[i].exp);
    end
    drive(0, 0, 0, 0, 0, 0);
    step;
    drive(1, 1, 1, 0, 0, 0);
    step;
    sweep(1, -1, 0);
    drive(1, 0, 1, 0, 0, 0);
    step;
    sweep(0, 3, 4);
    for (int n = 0; n < 3000; n++) begin
      r = n == 0 ? 1'b0 : $urandom_range(0, 59) != 0;
      rq = $urandom_range(0, 9) == 0;
      fq = $urandom_range(0, 7) == 0;
      rdy = $urandom_range(0, 3) != 0;
      c = $urandom_range(0, 2) != 0;
      dr = $urandom_range(0, 2) == 0;
      ex = m_exp();
      drive(r, rq, fq, rdy, c, dr);
      step;
      m_update(r, rq, fq, rdy, c, dr, ex[9]);
      check("random", obs, m_exp());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
